// File: rtl/seg7_mux_display.sv
// Multiplexed multi-digit 7-segment driver: hex decode, digit scanning, decimal points,
// leading-zero blanking and frame-synchronous (tear-free) display updates.
module seg7_mux_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    // Inactive levels double as XOR masks that turn "1 = lit/on" into the board polarity.
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    presc_tc;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;
    logic [4*NUM_DIGITS-1:0] shown_val;
    logic [NUM_DIGITS-1:0]   shown_dp;

    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              seg_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign presc_tc = en && (presc == PRESC_TC);
    assign wrap     = presc_tc && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (en) begin
            if (presc == PRESC_TC) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // A load on the wrap edge lands in pending after the commit has already used the old copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_vld  <= 1'b0;
            shown_val <= '0;
            shown_dp  <= '0;
        end else begin
            if (wrap && pend_vld) begin
                shown_val <= pend_val;
                shown_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // zero_from[k]: every shown nibble from digit k up to the leftmost digit is zero.
    always_comb begin
        zero_run  = 1'b1;
        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (shown_val[4*k +: 4] == 4'h0);
            zero_from[k] = zero_run;
        end
    end

    always_comb begin
        an_sel    = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                an_sel[k] = 1'b1;
                cur_nib   = shown_val[4*k +: 4];
                cur_dp    = shown_dp[k];
                cur_blank = blank_lz && (k != 0) && zero_from[k];
            end
        end
    end

    assign seg_lit = hex_to_seg(cur_nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (en) begin
                an  <= an_sel ^ AN_OFF;
                seg <= cur_blank ? SEG_OFF : (seg_lit ^ SEG_OFF);
                dp  <= cur_dp ^ DP_OFF;
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= DP_OFF;
            end
        end
    end

endmodule
